// File: rtl/uart_frame_pkg.sv
// Shared definitions for the inter-board UART frame transmitter.
//   - frame geometry constants (preamble byte/length, payload length)
//   - bit positions inside the flags byte
//   - FSM state encoding (GAP only exists with UART_FRAME_TX_GAP_EN)
//   - snapshot struct holding the captured game state
//   - pack_flags(): builds the flags byte from a snapshot
package uart_frame_pkg;

   localparam logic [7:0] PREAMBLE_BYTE = 8'hFF;
   localparam int         PREAMBLE_LEN  = 4;
   localparam int         PAYLOAD_LEN   = 10;
   localparam int         FRAME_LEN     = 14;
   localparam logic [3:0] LAST_IDX      = 4'(FRAME_LEN - 1);

   localparam int TANK_HIT_BIT  = 0;
   localparam int DIR_ENEMY_LSB = 1;
   localparam int DIR_TANK_LSB  = 4;
   localparam int OBSTACLE_BIT  = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
`ifdef UART_FRAME_TX_GAP_EN
      ,
      ST_GAP   = 2'd3
`endif
   } state_t;

   typedef struct packed {
      logic [15:0] xpos_tank;
      logic [15:0] ypos_tank;
      logic [9:0]  xpos_bullet;
      logic [9:0]  ypos_bullet;
      logic [7:0]  hp;
      logic [2:0]  direction_for_enemy;
      logic        tank_hit;
      logic [1:0]  direction_tank;
      logic        obstacle_hit;
   } snap_t;

   function automatic logic [7:0] pack_flags(input snap_t s);
      logic [7:0] f;
      f = '0;
      f[TANK_HIT_BIT]            = s.tank_hit;
      f[DIR_ENEMY_LSB +: 3]      = s.direction_for_enemy;
      f[DIR_TANK_LSB +: 2]       = s.direction_tank;
      f[OBSTACLE_BIT]            = s.obstacle_hit;
      return f;
   endfunction

endpackage

// File: rtl/uart_frame_byte_sel.sv
// Combinational frame byte selector.
//   snap     : captured game state
//   index    : frame byte index 0..13
//   byte_out : byte at that index (0..3 preamble, 4..13 payload,
//              16-bit fields little-endian, bullet fields zero-extended)
module uart_frame_byte_sel
   import uart_frame_pkg::*;
(
   input  snap_t      snap,
   input  logic [3:0] index,
   output logic [7:0] byte_out
);

   always_comb begin
      byte_out = PREAMBLE_BYTE;
      case (index)
         4'd4:    byte_out = snap.xpos_tank[7:0];
         4'd5:    byte_out = snap.xpos_tank[15:8];
         4'd6:    byte_out = snap.ypos_tank[7:0];
         4'd7:    byte_out = snap.ypos_tank[15:8];
         4'd8:    byte_out = snap.xpos_bullet[7:0];
         4'd9:    byte_out = {6'b0, snap.xpos_bullet[9:8]};
         4'd10:   byte_out = snap.ypos_bullet[7:0];
         4'd11:   byte_out = {6'b0, snap.ypos_bullet[9:8]};
         4'd12:   byte_out = snap.hp;
         4'd13:   byte_out = pack_flags(snap);
         default: byte_out = PREAMBLE_BYTE;
      endcase
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Transmit-side framer for the inter-board UART link.
// On send_req (sampled in IDLE) the game state is snapshotted and a 14-byte
// frame (4 x 0xFF preamble + 10 payload bytes) is handed to the UART TX one
// byte per tx_start/tx_done handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   send_req            : request one frame (ignored while busy, not queued)
//   xpos_tank..obstacle_hit : live game state, captured on acceptance
//   tx_done             : UART TX finished current byte (honoured in WAIT only)
//   tx_start, tx_data   : byte load pulse / byte, stable until its tx_done
//   busy                : any state other than IDLE
//   frame_done          : pulse the cycle after the last byte's tx_done
// Build option: UART_FRAME_TX_GAP_EN adds a GAP state holding busy for
// GAP_CYCLES (>= 1) clocks after each frame; otherwise GAP_CYCLES is ignored.
module uart_frame_tx
   import uart_frame_pkg::*;
#(
   parameter int GAP_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send_req,
   input  logic [15:0] xpos_tank,
   input  logic [15:0] ypos_tank,
   input  logic [9:0]  xpos_bullet,
   input  logic [9:0]  ypos_bullet,
   input  logic [7:0]  hp,
   input  logic [2:0]  direction_for_enemy,
   input  logic        tank_hit,
   input  logic [1:0]  direction_tank,
   input  logic        obstacle_hit,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        frame_done
);

   state_t     state, state_d;
   snap_t      snap, snap_d, live;
   logic [3:0] idx, idx_d, idx_inc;
   logic [7:0] tx_data_d, next_byte;
   logic       frame_done_d;

`ifdef UART_FRAME_TX_GAP_EN
   localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
`else
   // GAP_CYCLES has no effect in this build.
   if (GAP_CYCLES < 1) begin : g_gap_ignored
   end
`endif

   always_comb begin
      live.xpos_tank           = xpos_tank;
      live.ypos_tank           = ypos_tank;
      live.xpos_bullet         = xpos_bullet;
      live.ypos_bullet         = ypos_bullet;
      live.hp                  = hp;
      live.direction_for_enemy = direction_for_enemy;
      live.tank_hit            = tank_hit;
      live.direction_tank      = direction_tank;
      live.obstacle_hit        = obstacle_hit;
   end

   // tx_data is registered so it is valid in the START cycle. The selector
   // looks one byte ahead (idx + 1) from the registered snapshot; byte 0 is
   // always preamble, so the IDLE->START load never needs the snapshot.
   assign idx_inc = idx + 4'd1;

   uart_frame_byte_sel u_byte_sel (
      .snap     (snap),
      .index    (idx_inc),
      .byte_out (next_byte)
   );

   assign tx_start = (state == ST_START);
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         snap       <= '0;
         idx        <= '0;
         tx_data    <= '0;
         frame_done <= 1'b0;
`ifdef UART_FRAME_TX_GAP_EN
         gap_cnt    <= '0;
`endif
      end else begin
         state      <= state_d;
         snap       <= snap_d;
         idx        <= idx_d;
         tx_data    <= tx_data_d;
         frame_done <= frame_done_d;
`ifdef UART_FRAME_TX_GAP_EN
         gap_cnt    <= gap_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d      = state;
      snap_d       = snap;
      idx_d        = idx;
      tx_data_d    = tx_data;
      frame_done_d = 1'b0;
`ifdef UART_FRAME_TX_GAP_EN
      gap_cnt_d    = gap_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (send_req) begin
               snap_d    = live;
               idx_d     = '0;
               tx_data_d = PREAMBLE_BYTE;
               state_d   = ST_START;
            end
         end
         // tx_done in this cycle belongs to no byte of ours and is dropped.
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (tx_done) begin
               if (idx == LAST_IDX) begin
                  frame_done_d = 1'b1;
`ifdef UART_FRAME_TX_GAP_EN
                  gap_cnt_d    = '0;
                  state_d      = ST_GAP;
`else
                  state_d      = ST_IDLE;
`endif
               end else begin
                  idx_d     = idx_inc;
                  tx_data_d = next_byte;
                  state_d   = ST_START;
               end
            end
         end
`ifdef UART_FRAME_TX_GAP_EN
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) state_d = ST_IDLE;
            else                     gap_cnt_d = gap_cnt + 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
`timescale 1ns/1ps
module tb_uart_frame_tx;

   localparam int GAP = 8;
`ifdef UART_FRAME_TX_GAP_EN
   localparam int GAP_EXP = GAP;
`else
   localparam int GAP_EXP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst, send_req, tank_hit, obstacle_hit, tx_done;
   logic [15:0] xpos_tank, ypos_tank;
   logic [9:0]  xpos_bullet, ypos_bullet;
   logic [7:0]  hp, tx_data;
   logic [2:0]  direction_for_enemy;
   logic [1:0]  direction_tank;
   logic        tx_start, busy, frame_done;

   always #5 clk = ~clk;

   uart_frame_tx #(.GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .send_req(send_req),
      .xpos_tank(xpos_tank), .ypos_tank(ypos_tank),
      .xpos_bullet(xpos_bullet), .ypos_bullet(ypos_bullet), .hp(hp),
      .direction_for_enemy(direction_for_enemy), .tank_hit(tank_hit),
      .direction_tank(direction_tank), .obstacle_hit(obstacle_hit),
      .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
      .busy(busy), .frame_done(frame_done)
   );

   int errors = 0, checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] s1_exp [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h34, 8'h12, 8'h67,
                               8'h05, 8'hAB, 8'h02, 8'h55, 8'h01, 8'h64, 8'h6B};
   logic [7:0] p2_exp [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hBE, 8'hFF,
                               8'h00, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h00, 8'h14};
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   // UART TX model: tx_done 10 cycles after tx_start, 1 clock per line bit
   int         ucnt = 0;
   logic [7:0] ush = '0;
   logic       line;
   int         stab_bad = 0;
   assign line = (ucnt == 9) ? 1'b0 : (ucnt >= 1) ? ush[8-ucnt] : 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         ucnt <= 0; tx_done <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (ucnt == 0) begin
            if (tx_start === 1'b1) begin ucnt <= 9; ush <= tx_data; end
         end else begin
            if (ucnt == 1) tx_done <= 1'b1;
            ucnt <= ucnt - 1;
            if (tx_data !== ush) stab_bad <= stab_bad + 1;
         end
      end
   end

   // output monitor
   int n_starts = 0, fd_count = 0, last_done_cyc = 0;
   always @(posedge clk) begin
      if (tx_start === 1'b1) begin obs_q.push_back(tx_data); n_starts <= n_starts + 1; end
      if (tx_done === 1'b1) last_done_cyc <= cyc;
      if (frame_done === 1'b1) fd_count <= fd_count + 1;
   end

   // UART RX model + peer frame decoder
   int         rcnt = 0, pre = 0, k = 0, rx_frames = 0;
   logic [7:0] rsh = '0, rx_b = '0;
   logic       rx_vld = 1'b0, collecting = 1'b0;
   logic [7:0] pay [10];
   logic [15:0] rx_xt, rx_yt;
   logic [9:0]  rx_xb, rx_yb;
   logic [7:0]  rx_hp;
   logic [2:0]  rx_de;
   logic [1:0]  rx_dt;
   logic        rx_th, rx_oh;

   always @(posedge clk) begin
      rx_vld <= 1'b0;
      if (rst) rcnt <= 0;
      else if (rcnt == 0) begin
         if (line == 1'b0) rcnt <= 8;
      end else begin
         rsh  <= {line, rsh[7:1]};
         rcnt <= rcnt - 1;
         if (rcnt == 1) begin rx_vld <= 1'b1; rx_b <= {line, rsh[7:1]}; end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         pre <= 0; k <= 0; collecting <= 1'b0;
      end else if (rx_vld) begin
         if (!collecting) begin
            if (rx_b == 8'hFF) begin
               if (pre == 3) begin collecting <= 1'b1; k <= 0; pre <= 0; end
               else pre <= pre + 1;
            end else pre <= 0;
         end else begin
            pay[k] <= rx_b;
            if (k == 9) begin
               collecting <= 1'b0;
               rx_xt <= {pay[1], pay[0]};
               rx_yt <= {pay[3], pay[2]};
               rx_xb <= {pay[5][1:0], pay[4]};
               rx_yb <= {pay[7][1:0], pay[6]};
               rx_hp <= pay[8];
               rx_th <= rx_b[0];
               rx_de <= rx_b[3:1];
               rx_dt <= rx_b[5:4];
               rx_oh <= rx_b[6];
               rx_frames <= rx_frames + 1;
            end else k <= k + 1;
         end
      end
   end

   task automatic set_in(input logic [15:0] xt, yt, input logic [9:0] xb, yb,
                         input logic [7:0] h, input logic [2:0] de, input logic th,
                         input logic [1:0] dt, input logic oh);
      xpos_tank = xt; ypos_tank = yt; xpos_bullet = xb; ypos_bullet = yb; hp = h;
      direction_for_enemy = de; tank_hit = th; direction_tank = dt; obstacle_hit = oh;
   endtask

   task automatic set_s1();
      set_in(16'h1234, 16'h0567, 10'h2AB, 10'h155, 8'h64, 3'b101, 1'b1, 2'b10, 1'b1);
   endtask

   // bounded wait; returns at the negedge inside the frame_done cycle
   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; send_req = 1'b0;
      set_in('0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_frame();
      bit ok; int fd0, rf0, n_req; logic [7:0] o, e;
      fd0 = fd_count; rf0 = rx_frames;
      set_s1();
      foreach (s1_exp[i]) exp_q.push_back(s1_exp[i]);
      send_req = 1'b1; n_req = cyc;
      @(negedge clk); send_req = 1'b0;
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL sf_first_start: got %b want 1", tx_start); end
      checks++; if (tx_data !== 8'hFF) begin errors++; $display("FAIL sf_first_data: got %h want ff", tx_data); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sf_busy: got %b want 1", busy); end
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL sf_timeout: no frame_done within 400 cycles"); end
      checks++; if (cyc - last_done_cyc != 1) begin errors++; $display("FAIL sf_done_latency: got %0d want 1", cyc - last_done_cyc); end
      checks++; if (cyc - n_req != 155) begin errors++; $display("FAIL sf_frame_len: got %0d want 155", cyc - n_req); end
      checks++; if (busy !== (GAP_EXP != 0)) begin errors++; $display("FAIL sf_busy_at_done: got %b want %b", busy, GAP_EXP != 0); end
      repeat (GAP_EXP + 30) @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL sf_byte%0d: got none want %h", i, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL sf_byte%0d: got %h want %h", i, o, e); end end
      end
      checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL sf_frame_done_count: got %0d want 1", fd_count - fd0); end
      checks++; if (stab_bad != 0) begin errors++; $display("FAIL sf_tx_data_stable: got %0d changes want 0", stab_bad); end
      checks++; if (rx_frames - rf0 != 1) begin errors++; $display("FAIL lb_frames: got %0d want 1", rx_frames - rf0); end
      checks++;
      if ({rx_xt, rx_yt, rx_xb, rx_yb, rx_hp} !== {16'h1234, 16'h0567, 10'h2AB, 10'h155, 8'h64}) begin
         errors++; $display("FAIL lb_fields: got %h %h %h %h %h want 1234 0567 2ab 155 64", rx_xt, rx_yt, rx_xb, rx_yb, rx_hp);
      end
      checks++;
      if ({rx_de, rx_th, rx_dt, rx_oh} !== {3'b101, 1'b1, 2'b10, 1'b1}) begin
         errors++; $display("FAIL lb_flags: got de=%b th=%b dt=%b oh=%b want 101 1 10 1", rx_de, rx_th, rx_dt, rx_oh);
      end
   endtask

   task automatic test_snapshot();
      bit ok; logic [7:0] o, e;
      set_s1();
      foreach (s1_exp[i]) exp_q.push_back(s1_exp[i]);
      send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      set_in(16'hFFFF, 16'h0000, 10'h3FF, 10'h000, 8'hAA, 3'b010, 1'b0, 2'b01, 1'b0);
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL snap_timeout: no frame_done within 400 cycles"); end
      repeat (GAP_EXP + 5) @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL snap_byte%0d: got none want %h", i, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL snap_byte%0d: got %h want %h", i, o, e); end end
      end
   endtask

   task automatic test_busy_ignore();
      bit ok; int n0, fd0; logic [7:0] o, e;
      n0 = n_starts; fd0 = fd_count;
      set_s1();
      foreach (s1_exp[i]) exp_q.push_back(s1_exp[i]);
      send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      for (int n = 0; n < 200 && n_starts - n0 < 4; n++) @(negedge clk);
      send_req = 1'b1; @(negedge clk); send_req = 1'b0;
      for (int n = 0; n < 200 && n_starts - n0 < 10; n++) @(negedge clk);
      send_req = 1'b1; @(negedge clk); send_req = 1'b0;
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: no frame_done within 400 cycles"); end
      repeat (GAP_EXP + 40) @(negedge clk);
      checks++; if (n_starts - n0 != 14) begin errors++; $display("FAIL busy_start_count: got %0d want 14", n_starts - n0); end
      checks++; if (fd_count - fd0 != 1) begin errors++; $display("FAIL busy_frame_done_count: got %0d want 1", fd_count - fd0); end
      for (int i = 0; i < 14; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL busy_byte%0d: got none want %h", i, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL busy_byte%0d: got %h want %h", i, o, e); end end
      end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      bit ok, seen; int m, gb, fd0; logic [7:0] o, e;
      fd0 = fd_count;
      set_s1();
      for (int f = 0; f < 2; f++) foreach (s1_exp[i]) exp_q.push_back(s1_exp[i]);
      send_req = 1'b1;
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_timeout1: no frame_done within 400 cycles"); end
      m = last_done_cyc; gb = 0;
      while (busy === 1'b1 && gb < GAP + 4) begin gb++; @(negedge clk); end
      checks++; if (gb != GAP_EXP) begin errors++; $display("FAIL hold_gap_busy: got %0d cycles want %0d", gb, GAP_EXP); end
      seen = 1'b0;
      for (int n = 0; n < GAP + 10; n++) begin
         if (tx_start === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!seen || cyc - m != 2 + GAP_EXP) begin
         errors++; $display("FAIL hold_restart: got offset %0d (seen=%b) want %0d", cyc - m, seen, 2 + GAP_EXP);
      end
      send_req = 1'b0;
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_timeout2: no frame_done within 400 cycles"); end
      repeat (GAP_EXP + 30) @(negedge clk);
      checks++; if (fd_count - fd0 != 2) begin errors++; $display("FAIL hold_frame_done_count: got %0d want 2", fd_count - fd0); end
      for (int i = 0; i < 28; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL hold_byte%0d: got none want %h", i, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL hold_byte%0d: got %h want %h", i, o, e); end end
      end
      obs_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      bit ok; int n0; logic [7:0] o, e;
      n0 = n_starts;
      set_s1();
      send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      for (int n = 0; n < 200 && n_starts - n0 < 7; n++) @(negedge clk);
      checks++; if (n_starts - n0 != 7) begin errors++; $display("FAIL rstmid_reach_byte6: got %0d starts want 7", n_starts - n0); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start: got %b want 0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_frame_done: got %b want 0", frame_done); end
      rst = 1'b0;
      obs_q.delete();
      repeat (5) @(negedge clk);
      set_in(16'hBEEF, 16'h00FF, 10'h3FF, 10'h000, 8'h00, 3'b010, 1'b0, 2'b01, 1'b0);
      foreach (p2_exp[i]) exp_q.push_back(p2_exp[i]);
      send_req = 1'b1;
      @(negedge clk); send_req = 1'b0;
      checks++;
      if (tx_start !== 1'b1 || tx_data !== 8'hFF) begin
         errors++; $display("FAIL rstmid_restart: got start=%b data=%h want 1 ff", tx_start, tx_data);
      end
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: no frame_done within 400 cycles"); end
      repeat (GAP_EXP + 5) @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_byte%0d: got none want %h", i, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, o, e); end end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_snapshot();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
